// File: rtl/priority_pkg.sv
// Shared types for the priority bit streamer.
package priority_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/priority_bit_streamer_if.sv
// Input word handshake plus output beat handshake of the priority bit streamer.
interface priority_bit_streamer_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             msb_first_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] onehot_o;
    logic [IDX_W-1:0] index_o;
    logic             last_o;
    logic             empty_o;
    logic             data_val_o;
    logic             data_ready_i;

    modport slave (
        input  data_i, data_val_i, msb_first_i, data_ready_i,
        output data_ready_o, onehot_o, index_o, last_o, empty_o, data_val_o
    );

    modport master (
        output data_i, data_val_i, msb_first_i, data_ready_i,
        input  data_ready_o, onehot_o, index_o, last_o, empty_o, data_val_o
    );
endinterface

// File: rtl/priority_select.sv
// Combinational pick of the lowest or highest set bit of a word, with its index
// and a flag telling whether more than one bit is set.
module priority_select #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             msb_first_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic             multi_o
);

    // Later loop iterations overwrite earlier ones, so the scan direction picks the winner.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        if (msb_first_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (word_i[i]) begin
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                    index_o     = IDX_W'(i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (word_i[i]) begin
                    onehot_o    = '0;
                    onehot_o[i] = 1'b1;
                    index_o     = IDX_W'(i);
                end
            end
        end
    end

    assign multi_o = |(word_i & (word_i - WIDTH'(1)));

endmodule

// File: rtl/priority_bit_streamer.sv
// Decomposes an accepted word into one beat per set bit, LSB- or MSB-first,
// with a single empty beat for an all-zero word.
//
// state  | meaning
// IDLE   | no word held, ready for a new word
// STREAM | word held in rem_q, presenting its next set bit
module priority_bit_streamer
    import priority_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    priority_bit_streamer_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_index;
    logic             sel_multi;

    logic             ready;
    logic             val;
    logic [WIDTH-1:0] onehot;
    logic [IDX_W-1:0] index;
    logic             last;
    logic             empty;

    priority_select #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_select (
        .word_i      (rem_q),
        .msb_first_i (mode_q),
        .onehot_o    (sel_onehot),
        .index_o     (sel_index),
        .multi_o     (sel_multi)
    );

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        ready   = 1'b0;
        val     = 1'b0;
        onehot  = '0;
        index   = '0;
        last    = 1'b0;
        empty   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.data_val_i) begin
                    state_d = STREAM;
                    rem_d   = bus.data_i;
                    mode_d  = bus.msb_first_i;
                end
            end
            STREAM: begin
                val    = 1'b1;
                onehot = sel_onehot;
                index  = sel_index;
                last   = !sel_multi;
                empty  = (rem_q == '0);
                if (bus.data_ready_i) begin
                    if (!sel_multi) begin
                        // Final beat leaves: take the next word in the same cycle to avoid a bubble.
                        ready = 1'b1;
                        if (bus.data_val_i) begin
                            rem_d  = bus.data_i;
                            mode_d = bus.msb_first_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        rem_d = rem_q & ~sel_onehot;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_ready_o = ready;
    assign bus.data_val_o   = val;
    assign bus.onehot_o     = onehot;
    assign bus.index_o      = index;
    assign bus.last_o       = last;
    assign bus.empty_o      = empty;

endmodule

// File: tb/tb_priority_bit_streamer.sv
// Scoreboard bench for priority_bit_streamer at WIDTH 2, 16 and 64.
module tb_priority_bit_streamer;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit drv_done [NI];
    int drv_err  [NI];
    int q_left   [NI];

    typedef struct {
        logic [63:0] word;
        bit          mode;
        int          rdy;
        bit          b2b;
        bit          rst3;
    } stim_t;

    typedef struct {
        logic [63:0] oh;
        int          idx;
        bit          last;
        bit          empty;
    } beat_t;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int W  = (g == 0) ? 2 : ((g == 1) ? 16 : 64);
        localparam int IW = $clog2(W);

        logic srst;
        int   rdy_mode;
        int   beat_cnt = 0;
        beat_t exp_q[$];
        stim_t sq[$];

        priority_bit_streamer_if #(.WIDTH(W)) sif ();

        priority_bit_streamer #(.WIDTH(W)) dut (
            .clk_i  (clk),
            .srst_i (srst),
            .bus    (sif.slave)
        );

        task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL W=%0d %s: got %0h expected %0h at %0t", W, nm, act, exp, $time);
            end
        endtask

        function automatic void push_exp(input logic [63:0] word, input bit mode);
            beat_t b;
            int n;
            int i;
            n = 0;
            for (int k = 0; k < W; k++) if (word[k]) n++;
            if (n == 0) begin
                b.oh = 64'd0; b.idx = 0; b.last = 1'b1; b.empty = 1'b1;
                exp_q.push_back(b);
            end else begin
                for (int k = 0; k < W; k++) begin
                    i = mode ? (W - 1 - k) : k;
                    if (word[i]) begin
                        n--;
                        b.oh = 64'd1 << i; b.idx = i; b.last = (n == 0); b.empty = 1'b0;
                        exp_q.push_back(b);
                    end
                end
            end
        endfunction

        // Downstream ready: 0 held high, 1 toggling, 2 random, 3 held low.
        initial begin
            forever begin
                @(posedge clk);
                #2;
                case (rdy_mode)
                    0:       sif.data_ready_i = 1'b1;
                    1:       sif.data_ready_i = ~sif.data_ready_i;
                    3:       sif.data_ready_i = 1'b0;
                    default: sif.data_ready_i = ($urandom_range(0, 3) != 0);
                endcase
            end
        end

        bit prev_in_hs = 1'b0;
        bit prev_out_more = 1'b0;
        bit chk_rst = 1'b0;
        bit held_v = 1'b0;
        logic [W-1:0]  held_oh;
        logic [IW-1:0] held_idx;
        logic          held_last, held_empty;

        always @(negedge clk) begin
            beat_t e;
            bit in_hs, out_hs;
            in_hs  = sif.data_val_i && sif.data_ready_o;
            out_hs = sif.data_val_o && sif.data_ready_i;
            if (chk_rst) begin
                chk("rst_val_o", 64'(sif.data_val_o), 64'd0);
                chk("rst_ready_o", 64'(sif.data_ready_o), 64'd1);
            end
            if (prev_in_hs) chk("first_beat_latency", 64'(sif.data_val_o), 64'd1);
            if (prev_out_more) chk("beat_gap", 64'(sif.data_val_o), 64'd1);
            chk("ready_rule", 64'(sif.data_ready_o),
                64'(!sif.data_val_o || (sif.data_ready_i && sif.last_o)));
            if (!sif.data_val_o)
                chk("idle_outputs", 64'((|sif.onehot_o) | (|sif.index_o) | sif.last_o | sif.empty_o), 64'd0);
            if (held_v) begin
                chk("stall_onehot", 64'(sif.onehot_o), 64'(held_oh));
                chk("stall_index", 64'(sif.index_o), 64'(held_idx));
                chk("stall_flags", {62'd0, sif.last_o, sif.empty_o}, {62'd0, held_last, held_empty});
            end
            if (srst) begin
                exp_q.delete();
                held_v = 1'b0;
                prev_in_hs = 1'b0;
                prev_out_more = 1'b0;
                chk_rst = 1'b1;
            end else begin
                chk_rst = 1'b0;
                if (out_hs) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat_index", 64'(sif.index_o), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_onehot", 64'(sif.onehot_o), e.oh);
                        chk("beat_index", 64'(sif.index_o), 64'(e.idx));
                        chk("beat_last", 64'(sif.last_o), 64'(e.last));
                        chk("beat_empty", 64'(sif.empty_o), 64'(e.empty));
                    end
                    beat_cnt++;
                end
                held_v     = sif.data_val_o && !sif.data_ready_i;
                held_oh    = sif.onehot_o;
                held_idx   = sif.index_o;
                held_last  = sif.last_o;
                held_empty = sif.empty_o;
                prev_in_hs = in_hs;
                prev_out_more = out_hs && !sif.last_o;
            end
            q_left[g] = exp_q.size();
        end

        initial begin
            stim_t s;
            bit    accepted;
            int    start_cnt;
            logic [63:0] mask;
            mask = {64{1'b1}} >> (64 - W);
            srst = 1'b1;
            rdy_mode = 0;
            sif.data_val_i = 1'b0;
            sif.data_i = '0;
            sif.msb_first_i = 1'b0;
            sif.data_ready_i = 1'b1;
            drv_err[g] = 0;
            drv_done[g] = 1'b0;
            if (W == 16) begin
                sq.push_back('{64'h8421, 1'b0, 0, 1'b0, 1'b0});
                sq.push_back('{64'h8421, 1'b1, 1, 1'b0, 1'b0});
                sq.push_back('{64'h0000, 1'b0, 0, 1'b0, 1'b0});
                sq.push_back('{64'h0003, 1'b0, 0, 1'b1, 1'b0});
                sq.push_back('{64'h0100, 1'b0, 0, 1'b0, 1'b0});
                sq.push_back('{64'hFFFF, 1'b0, 0, 1'b0, 1'b1});
                sq.push_back('{64'hFFFF, 1'b1, 0, 1'b0, 1'b0});
                sq.push_back('{64'h0005, 1'b1, 2, 1'b1, 1'b0});
            end
            for (int r = 0; r < 40; r++) begin
                s.word = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) s.word = 64'd0;
                s.mode = 1'($urandom_range(0, 1));
                s.rdy  = 2;
                s.b2b  = 1'($urandom_range(0, 1));
                s.rst3 = 1'b0;
                sq.push_back(s);
            end
            repeat (3) @(posedge clk);
            #1 srst = 1'b0;
            while (sq.size() > 0) begin
                s = sq.pop_front();
                rdy_mode = s.rdy;
                sif.data_i = s.word[W-1:0];
                sif.msb_first_i = s.mode;
                sif.data_val_i = 1'b1;
                accepted = 1'b0;
                start_cnt = beat_cnt;
                for (int c = 0; c < 300 && !accepted; c++) begin
                    @(negedge clk);
                    if (sif.data_ready_o) begin
                        push_exp(s.word & mask, s.mode);
                        accepted = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                end
                if (!accepted) drv_err[g]++;
                if (s.b2b && sq.size() > 0) continue;
                sif.data_val_i = 1'b0;
                sif.data_i = W'({$urandom, $urandom});
                sif.msb_first_i = 1'($urandom_range(0, 1));
                if (s.rst3) begin
                    for (int c = 0; c < 300 && beat_cnt < start_cnt + 3; c++) begin
                        @(posedge clk);
                        #1;
                    end
                    if (beat_cnt < start_cnt + 3) drv_err[g]++;
                    srst = 1'b1;
                    rdy_mode = 3;
                    @(posedge clk);
                    #1;
                    srst = 1'b0;
                    rdy_mode = 0;
                end
                for (int c = 0; c < 2000 && (exp_q.size() != 0 || sif.data_val_o); c++) begin
                    @(posedge clk);
                    #1;
                end
                if (exp_q.size() != 0 || sif.data_val_o) drv_err[g]++;
            end
            repeat (4) @(posedge clk);
            drv_done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (drv_done[0] && drv_done[1] && drv_done[2]) break;
        end
        repeat (5) @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (!drv_done[i]) begin
                n_fail++;
                $display("FAIL inst%0d driver_done: got 0 expected 1", i);
            end
            n_tests++;
            if (drv_err[i] != 0) begin
                n_fail++;
                $display("FAIL inst%0d driver_timeouts: got %0d expected 0", i, drv_err[i]);
            end
            n_tests++;
            if (q_left[i] != 0) begin
                n_fail++;
                $display("FAIL inst%0d beats_outstanding: got %0d expected 0", i, q_left[i]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_bit_streamer.md
PRIORITY_BIT_STREAMER -- requirements
Module: priority_bit_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning input word width in bits (legal range 2..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(WIDTH), meaning index output width; not overridden by instantiators.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 srst_i  input  1  reset, synchronous, active-high.
REQ-005 data_i  input  WIDTH  word to decompose into set bits.
REQ-006 data_val_i  input  1  data_i and msb_first_i valid.
REQ-007 msb_first_i  input  1  order for this word: 0 = LSB first, 1 = MSB first.
REQ-008 data_ready_o  output  1  block accepts a word this cycle.
REQ-009 onehot_o  output  WIDTH  current extracted bit as a one-hot word.
REQ-010 index_o  output  IDX_W  bit position of onehot_o.
REQ-011 last_o  output  1  current beat is the final beat of the word.
REQ-012 empty_o  output  1  current beat represents an all-zero word.
REQ-013 data_val_o  output  1  output beat valid.
REQ-014 data_ready_i  input  1  downstream accepts the beat.

Function
REQ-015 SHALL accept a word when data_val_i && data_ready_o (input handshake) and register data_i into residual register rem and msb_first_i into mode register.
REQ-016 SHALL implement two states: IDLE (no word held) and STREAM (word held, data_val_o = 1).
REQ-017 SHALL transition IDLE -> STREAM on input handshake; STREAM -> IDLE on output handshake with last_o = 1 and no simultaneous input handshake; otherwise hold state.
REQ-018 SHALL drive data_ready_o = 1 in IDLE, and in STREAM only when data_val_o && data_ready_i && last_o (back-to-back word acceptance, no bubble).
REQ-019 SHALL present the first beat of an accepted word in the cycle after acceptance (latency 1), one beat per cycle while data_ready_i = 1.
REQ-020 SHALL in STREAM drive onehot_o = lowest set bit of rem when mode = 0, highest set bit when mode = 1; index_o = its position.
REQ-021 SHALL drive last_o = 1 when rem has at most one bit set.
REQ-022 SHALL, for an all-zero word, emit exactly one beat with onehot_o = 0, index_o = 0, empty_o = 1, last_o = 1.
REQ-023 SHALL on output handshake with last_o = 0 clear the emitted bit in rem; outputs SHALL hold stable while data_val_o && !data_ready_i.
REQ-024 SHALL drive onehot_o, index_o, last_o, empty_o to 0 in IDLE.
REQ-025 SHALL emit exactly popcount(word) beats for a non-zero word (WIDTH beats for all-ones), strictly increasing index when mode = 0, strictly decreasing when mode = 1.
REQ-026 SHALL ignore data_i and msb_first_i when no input handshake occurs.

Reset
REQ-027 SHALL on srst_i = 1 set state IDLE, rem = 0, mode = 0, regardless of state or pending handshakes; data_val_o = 0 and data_ready_o = 1 from the cycle after reset asserts.
REQ-028 SHALL discard any partially streamed word on reset; no beat of it SHALL appear after reset.

Structure
REQ-029 SHALL place the state enum (IDLE, STREAM) in shared package priority_pkg.
REQ-030 SHALL use one sub-module, priority_select (combinational, parameter WIDTH, inputs word and msb_first, outputs one-hot, index, more-than-one-bit flag), instanced once.
REQ-031 SHALL register only state, rem and mode; all outputs derived combinationally from them.

Verification
REQ-032 WIDTH=16, word 0x8421, mode 0, ready held 1 -> beats idx 0,5,10,15 on cycles 1-4 after accept, last_o only on idx 15.
REQ-033 WIDTH=16, word 0x8421, mode 1, data_ready_i toggling 1/0 -> beats idx 15,10,5,0, outputs stable during stall cycles.
REQ-034 Word 0x0000 -> single beat onehot 0, empty_o = 1, last_o = 1; then IDLE.
REQ-035 Words 0x0003 then 0x0100 offered back-to-back -> second accepted on cycle of idx 1 last handshake; beats 0,1,8 with no idle cycle.
REQ-036 srst_i asserted mid-stream of 0xFFFF after 3 beats -> next cycle data_val_o = 0, data_ready_o = 1; no further beats of 0xFFFF.
REQ-037 Random words, random modes, random data_ready_i, WIDTH 2, 16, 64 -> beat count equals popcount (1 for zero), order and OR of onehot_o match the word (scoreboard).
